mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one N-bit 4:1 multiplexer (mux4_Nbit) and its downstream valid/ready sink among four requesters. It arbitrates requests, drives the mux select, and presents each granted word downstream with a valid/ready handshake. Each accepted word is acknowledged back to its requester. A stalled sink is abandoned after a programmable timeout.

---
 rtl/mux4_rr_arbiter_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 32 +++
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
// Holds FSM state encodings, requester count and the reset pointer value.
// No logic; imported by the arbiter top and the round-robin picker.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Pointer value after reset: requester 0 is searched first.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Search for the next owner always begins one past the given index.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin picker: first set request bit scanning upward from i_start, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_start,
  output logic               o_hit,
  output logic [SEL_W-1:0]   o_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  logic [SEL_W-1:0] w_cand;

  // Scan the four positions in priority order, keeping the first hit.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = i_start;
    w_cand = i_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = i_start + SEL_W'(k);
      if (!o_hit && i_req[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand;
      end
    end
  end

  assign o_onehot = o_hit ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select and a valid/ready uplink.
// Latency: grant one cycle after request in IDLE; back-to-back grants on accept.
// Backpressure: holds grant while ready is low; drops it after TIMEOUT stalled cycles.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,  // 0 disables the stall timeout
  parameter int CNT_W   = 8     // TIMEOUT must fit: TIMEOUT < 2**CNT_W
)
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [SEL_W-1:0]   o_sel,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_timeout_err,
  output logic               o_busy
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t         r_state, w_state;
  logic [SEL_W-1:0]   r_sel, w_sel;
  logic [NUM_REQ-1:0] r_grant, w_grant;
  logic               r_out_valid, w_out_valid;
  logic               r_timeout_err, w_timeout_err;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [SEL_W-1:0]   r_last, w_last;

  logic               w_accept;
  logic [NUM_REQ-1:0] w_pick_req;
  logic [SEL_W-1:0]   w_pick_start;
  logic               w_hit;
  logic [SEL_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_onehot;

  assign w_accept = r_out_valid & i_out_ready;

  // One picker serves both cases: in IDLE it scans from the pointer, in GRANT it
  // re-arbitrates past the current owner, excluding the owner being acknowledged.
  assign w_pick_req   = (r_state == ST_IDLE) ? i_req : (i_req & ~r_grant);
  assign w_pick_start = (r_state == ST_IDLE) ? next_ptr(r_last) : next_ptr(r_sel);

  rr_pick4 u_pick (
    .i_req    (w_pick_req),
    .i_start  (w_pick_start),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // State register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_sel         <= '0;
      r_grant       <= '0;
      r_out_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
      r_last        <= PTR_RST;
    end else begin
      r_state       <= w_state;
      r_sel         <= w_sel;
      r_grant       <= w_grant;
      r_out_valid   <= w_out_valid;
      r_timeout_err <= w_timeout_err;
      r_cnt         <= w_cnt;
      r_last        <= w_last;
    end
  end

  // Next-state logic: accept beats abandon, abandon beats timeout.
  always_comb begin
    w_state       = r_state;
    w_sel         = r_sel;
    w_grant       = r_grant;
    w_out_valid   = r_out_valid;
    w_timeout_err = 1'b0;
    w_cnt         = r_cnt;
    w_last        = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state     = ST_GRANT;
          w_sel       = w_idx;
          w_grant     = w_onehot;
          w_out_valid = 1'b1;
          w_cnt       = '0;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_last = r_sel;
          w_cnt  = '0;
          if (w_hit) begin
            w_sel   = w_idx;
            w_grant = w_onehot;
          end else begin
            w_state     = ST_IDLE;
            w_grant     = '0;
            w_out_valid = 1'b0;
          end
        end else if (!i_req[r_sel]) begin
          // Requester withdrew: release silently, pointer untouched.
          w_state     = ST_IDLE;
          w_grant     = '0;
          w_out_valid = 1'b0;
          w_cnt       = '0;
        end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
          w_state       = ST_IDLE;
          w_grant       = '0;
          w_out_valid   = 1'b0;
          w_timeout_err = 1'b1;
          w_last        = r_sel;
          w_cnt         = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign o_sel         = r_sel;
  assign o_grant       = r_grant;
  assign o_out_valid   = r_out_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state == ST_GRANT);
  assign o_ack         = r_grant & {NUM_REQ{w_accept}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed vector table followed by random traffic
// checked against a behavioural round-robin model. TIMEOUT is set to 4.
module tb_mux4_rr_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rdy;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       vld;
  logic [3:0] ack;
  logic       terr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .o_sel         (sel),
    .o_grant       (grant),
    .o_out_valid   (vld),
    .i_out_ready   (rdy),
    .o_ack         (ack),
    .o_timeout_err (terr),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] ack;
    logic       terr;
    logic       chk_sel;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                              input logic [3:0] g, input logic [1:0] s, input logic v,
                              input logic [3:0] a, input logic e, input logic cs);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = y; t.grant = g; t.sel = s;
    t.vld = v; t.ack = a; t.terr = e; t.chk_sel = cs;
    return t;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic [3:0] ea, input logic et,
                           input logic cs);
    chk({tag, " grant"}, grant, eg);
    chk({tag, " out_valid"}, {3'b0, vld}, {3'b0, ev});
    chk({tag, " busy"}, {3'b0, busy}, {3'b0, ev});
    chk({tag, " ack"}, ack, ea);
    chk({tag, " timeout_err"}, {3'b0, terr}, {3'b0, et});
    if (cs) chk({tag, " sel"}, {2'b0, sel}, {2'b0, es});
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner;   // current owner index, -1 when nobody holds the grant
  int m_last;    // most recently served or dropped requester
  int m_sel;     // last select value driven
  int m_waited;  // cycles the current owner has been presented without acceptance
  bit m_err;

  function automatic int rr_search(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      int id;
      id = (from + k) % 4;
      if (mask[id]) return id;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_sel = 0; m_waited = 0; m_err = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] q, input logic y);
    int id;
    logic [3:0] others;
    if (r) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (m_owner < 0) begin
      id = rr_search(q, m_last);
      if (id >= 0) begin
        m_owner = id; m_sel = id; m_waited = 0;
      end
    end else if (y) begin
      m_last = m_owner;
      others = q;
      others[m_owner] = 1'b0;
      id = rr_search(others, m_owner);
      m_owner = id;
      if (id >= 0) m_sel = id;
      m_waited = 0;
    end else if (!q[m_owner]) begin
      m_owner = -1;
      m_waited = 0;
    end else begin
      m_waited++;
      if (TO != 0 && m_waited == TO) begin
        m_err = 1; m_last = m_owner; m_owner = -1; m_waited = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rq;
    logic [3:0] eg;
    logic       ev;
    int         bias;

    rst = 1'b1; req = 4'b0; rdy = 1'b0;

    // Directed table: inputs applied this cycle, outputs expected this cycle.
    //            rst  req      rdy  grant    sel  vld  ack      terr chk_sel
    vt.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 1)); // reset state
    vt.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
    vt.push_back(mk(0, 4'b0100, 1, 4'b0100, 2, 1, 4'b0100, 0, 1)); // single request
    vt.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // gap cycle
    vt.push_back(mk(0, 4'b0100, 1, 4'b0100, 2, 1, 4'b0100, 0, 1)); // every 2 cycles
    vt.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // reset pointer
    vt.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001, 0, 1)); // fairness 0
    vt.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 4'b0010, 0, 1)); // 1
    vt.push_back(mk(0, 4'b1111, 1, 4'b0100, 2, 1, 4'b0100, 0, 1)); // 2
    vt.push_back(mk(0, 4'b1111, 1, 4'b1000, 3, 1, 4'b1000, 0, 1)); // 3
    vt.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001, 0, 1)); // wrap to 0
    vt.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 0, 1)); // backpressure
    vt.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 1, 4'b0010, 0, 1)); // accept on threshold
    vt.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // no error after
    vt.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 4'b0000, 0, 0)); // timeout run
    vt.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 4'b0000, 0, 1)); // 4th valid cycle
    vt.push_back(mk(0, 4'b0011, 0, 4'b0000, 0, 0, 4'b0000, 1, 0)); // error pulse
    vt.push_back(mk(0, 4'b0011, 1, 4'b0010, 1, 1, 4'b0010, 0, 1)); // next is req 1
    vt.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 4'b0000, 0, 1)); // back-to-back to 0
    vt.push_back(mk(0, 4'b0000, 0, 4'b0001, 0, 1, 4'b0000, 0, 1)); // req[sel] drops
    vt.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0, 0)); // abandoned, no err
    vt.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));
    vt.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 4'b0000, 0, 1)); // pointer still 1
    vt.push_back(mk(1, 4'b1111, 0, 4'b0100, 2, 1, 4'b0000, 0, 1)); // reset mid-grant
    vt.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 0, 1)); // all cleared
    vt.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001, 0, 1)); // first grant to 0
    vt.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 0, 1));
    vt.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; req = vt[i].req; rdy = vt[i].rdy;
      #1;
      check_all($sformatf("vec%0d", i), vt[i].grant, vt[i].sel, vt[i].vld,
                vt[i].ack, vt[i].terr, vt[i].chk_sel);
    end

    // Random traffic against the reference model.
    @(negedge clk);
    rst = 1'b1; req = 4'b0; rdy = 1'b0;
    @(posedge clk);
    model_reset();
    rq = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bias = ((c / 64) % 2 == 0) ? 8 : 2;
      for (int b = 0; b < 4; b++) begin
        if (!rq[b]) rq[b] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 9) == 0) rq[b] = 1'b0;
      end
      rst = ($urandom_range(0, 299) == 0);
      req = rq;
      rdy = ($urandom_range(0, 9) < bias);
      #1;
      eg = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
      ev = (m_owner >= 0);
      check_all($sformatf("rnd%0d", c), eg, 2'(m_sel), ev,
                (ev && rdy) ? eg : 4'b0, m_err, ev);
      model_step(rst, req, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
